// File: rtl/fetch_controller_if.sv
// Fetch-side bus bundle: instruction-memory request/response plus the decode valid/ready handshake.
interface fetch_controller_if #(
  parameter int unsigned WORD_LEN      = 32,
  parameter int unsigned MEM_CELL_SIZE = 8
);

  logic                     mem_req;
  logic [MEM_CELL_SIZE-1:0] mem_addr;
  logic [WORD_LEN-1:0]      mem_data;
  logic [MEM_CELL_SIZE-1:0] pc;
  logic [WORD_LEN-1:0]      instr;
  logic                     instr_valid;
  logic                     out_ready;
  logic                     br_taken;
  logic [WORD_LEN-1:0]      br_offset;

  // Fetch controller side
  modport master (
    output mem_req, mem_addr, pc, instr, instr_valid,
    input  mem_data, out_ready, br_taken, br_offset
  );

  // Memory / decode side
  modport slave (
    input  mem_req, mem_addr, pc, instr, instr_valid,
    output mem_data, out_ready, br_taken, br_offset
  );

endinterface

// File: rtl/fetch_controller.sv
// Fetch sequencer: owns the PC, issues one instruction-memory request at a time, hands the word to decode.
// Optional macro FETCH_PERF_CNT_EN adds saturating fetch_count / stall_count outputs.
module fetch_controller #(
  parameter int unsigned WORD_LEN      = 32,
  parameter int unsigned MEM_CELL_SIZE = 8,
  parameter int unsigned MEM_LATENCY   = 1,
  parameter int unsigned RESET_PC      = 0
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                start,
  input  logic                halt,
  fetch_controller_if.master  bus,
  output logic                busy
`ifdef FETCH_PERF_CNT_EN
  ,
  output logic [15:0]         fetch_count,
  output logic [15:0]         stall_count
`endif
);

  localparam int unsigned AW    = MEM_CELL_SIZE;
  localparam int unsigned CNT_W = 4;
  localparam logic [CNT_W-1:0] LAT_LOAD = CNT_W'(MEM_LATENCY - 1);
  localparam logic [AW-1:0]    PC_START = AW'(RESET_PC);
  localparam logic [AW-1:0]    PC_STEP  = AW'(4);

  if (MEM_LATENCY < 1 || MEM_LATENCY > 15) begin : g_bad_latency
    $error("fetch_controller: MEM_LATENCY must be in 1..15");
  end

  typedef enum logic [1:0] {IDLE, REQ, WAIT, HOLD} state_t;

  state_t           state, state_nxt;
  logic [AW-1:0]    fetch_addr, fetch_addr_nxt;
  logic [CNT_W-1:0] lat_cnt, lat_cnt_nxt;
  logic             halt_pending, halt_pending_nxt;
  logic             capture_c;
  logic             handshake_c;

  assign handshake_c = bus.instr_valid & bus.out_ready;

  // Next-state, next fetch address, latency countdown and sticky halt
  always_comb begin
    state_nxt        = state;
    fetch_addr_nxt   = fetch_addr;
    lat_cnt_nxt      = lat_cnt;
    halt_pending_nxt = halt_pending;
    capture_c        = 1'b0;
    case (state)
      IDLE: begin
        if (start) begin
          fetch_addr_nxt = PC_START;
          state_nxt      = REQ;
        end
      end
      REQ: begin
        lat_cnt_nxt = LAT_LOAD;
        state_nxt   = WAIT;
        if (halt) halt_pending_nxt = 1'b1;
      end
      WAIT: begin
        if (halt) halt_pending_nxt = 1'b1;
        if (lat_cnt == '0) begin
          capture_c = 1'b1;
          state_nxt = HOLD;
        end else begin
          lat_cnt_nxt = lat_cnt - CNT_W'(1);
        end
      end
      HOLD: begin
        if (handshake_c) begin
          // Offset is truncated to the address width; both sums wrap naturally
          fetch_addr_nxt = bus.br_taken ? bus.pc + bus.br_offset[AW-1:0]
                                        : bus.pc + PC_STEP;
          if (halt || halt_pending) begin
            halt_pending_nxt = 1'b0;
            state_nxt        = IDLE;
          end else begin
            state_nxt = REQ;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // Control state
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state        <= IDLE;
      fetch_addr   <= '0;
      lat_cnt      <= '0;
      halt_pending <= 1'b0;
    end else begin
      state        <= state_nxt;
      fetch_addr   <= fetch_addr_nxt;
      lat_cnt      <= lat_cnt_nxt;
      halt_pending <= halt_pending_nxt;
    end
  end

  // Outputs are registered from the next state so they line up with the state they describe
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      bus.mem_req     <= 1'b0;
      bus.mem_addr    <= '0;
      bus.pc          <= '0;
      bus.instr       <= '0;
      bus.instr_valid <= 1'b0;
      busy            <= 1'b0;
    end else begin
      bus.mem_req     <= (state_nxt == REQ);
      bus.instr_valid <= (state_nxt == HOLD);
      busy            <= (state_nxt != IDLE);
      if (state_nxt == REQ) bus.mem_addr <= fetch_addr_nxt;
      if (capture_c) begin
        bus.instr <= bus.mem_data;
        bus.pc    <= fetch_addr;
      end
    end
  end

`ifdef FETCH_PERF_CNT_EN
  // Saturating handshake and backpressure counters; only rst clears them
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      fetch_count <= '0;
      stall_count <= '0;
    end else begin
      if (handshake_c && fetch_count != 16'hFFFF)
        fetch_count <= fetch_count + 16'd1;
      if (state == HOLD && !bus.out_ready && stall_count != 16'hFFFF)
        stall_count <= stall_count + 16'd1;
    end
  end
`endif

  a_req_single: assert property (@(posedge clk) disable iff (!rst)
    bus.mem_req |=> !bus.mem_req);

  a_hold_stable: assert property (@(posedge clk) disable iff (!rst)
    (bus.instr_valid && !bus.out_ready) |=>
      (bus.instr_valid && $stable(bus.instr) && $stable(bus.pc)));

endmodule

// File: tb/tb_fetch_controller.sv
// Scoreboard bench for fetch_controller: one instance at MEM_LATENCY=1, one at MEM_LATENCY=3.
`timescale 1ns/1ps
module tb_fetch_controller;

  localparam int unsigned WL = 32;
  localparam int unsigned AW = 8;

  typedef struct packed {
    logic [AW-1:0] addr;
    logic [WL-1:0] data;
  } exp_t;

  logic clk = 1'b0;
  logic rst;
  logic start1, halt1, busy1;
  logic start3, halt3, busy3;
  int   cyc = 0;
  int   checks = 0;
  int   failures = 0;
  exp_t sb1[$];
  exp_t sb3[$];

  fetch_controller_if #(.WORD_LEN(WL), .MEM_CELL_SIZE(AW)) bus1 ();
  fetch_controller_if #(.WORD_LEN(WL), .MEM_CELL_SIZE(AW)) bus3 ();

`ifdef FETCH_PERF_CNT_EN
  logic [15:0] fcnt1, scnt1, fcnt3, scnt3;
  int hs1;
  always @(posedge clk or negedge rst)
    if (!rst) hs1 <= 0;
    else if (bus1.instr_valid && bus1.out_ready) hs1 <= hs1 + 1;
`endif

  fetch_controller #(.WORD_LEN(WL), .MEM_CELL_SIZE(AW), .MEM_LATENCY(1), .RESET_PC(0)) u_dut1 (
    .clk(clk), .rst(rst), .start(start1), .halt(halt1), .bus(bus1), .busy(busy1)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fcnt1), .stall_count(scnt1)
`endif
  );

  fetch_controller #(.WORD_LEN(WL), .MEM_CELL_SIZE(AW), .MEM_LATENCY(3), .RESET_PC(0)) u_dut3 (
    .clk(clk), .rst(rst), .start(start3), .halt(halt3), .bus(bus3), .busy(busy3)
`ifdef FETCH_PERF_CNT_EN
    , .fetch_count(fcnt3), .stall_count(scnt3)
`endif
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  function automatic logic [WL-1:0] memfn(input logic [AW-1:0] a);
    memfn = (a == '0) ? 32'hDEAD_BEEF : {16'hC0DE, 8'h5A, a};
  endfunction

  // Instruction memory models: data valid only in the cycle exactly L cycles after mem_req
  logic       pend1, pend3;
  logic [3:0] rem1, rem3;
  logic [7:0] raddr1, raddr3;

  always @(posedge clk or negedge rst)
    if (!rst) begin pend1 <= 1'b0; rem1 <= '0; raddr1 <= '0; end
    else if (bus1.mem_req) begin pend1 <= 1'b1; rem1 <= 4'd0; raddr1 <= bus1.mem_addr; end
    else if (pend1) begin
      if (rem1 == 4'd0) pend1 <= 1'b0;
      else rem1 <= rem1 - 4'd1;
    end

  always @(posedge clk or negedge rst)
    if (!rst) begin pend3 <= 1'b0; rem3 <= '0; raddr3 <= '0; end
    else if (bus3.mem_req) begin pend3 <= 1'b1; rem3 <= 4'd2; raddr3 <= bus3.mem_addr; end
    else if (pend3) begin
      if (rem3 == 4'd0) pend3 <= 1'b0;
      else rem3 <= rem3 - 4'd1;
    end

  assign bus1.mem_data = (pend1 && rem1 == 4'd0) ? memfn(raddr1) : 32'hBAD0_BAD0;
  assign bus3.mem_data = (pend3 && rem3 == 4'd0) ? memfn(raddr3) : 32'hBAD0_BAD0;

  task automatic wait_req1(output int t, output logic [AW-1:0] a);
    t = -1; a = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.mem_req) begin t = cyc; a = bus1.mem_addr; break; end
    end
  endtask

  task automatic wait_valid1(output int t, output logic [AW-1:0] p, output logic [WL-1:0] ins);
    t = -1; p = '0; ins = '0;
    for (int i = 0; i < 20; i++) begin
      @(negedge clk);
      if (bus1.instr_valid) begin t = cyc; p = bus1.pc; ins = bus1.instr; break; end
    end
  endtask

  // Hand off the held instruction with the given branch inputs and wait for the next one
  task automatic xfer1(input logic br, input logic [WL-1:0] off,
                       output logic [AW-1:0] a, output int tv,
                       output logic [AW-1:0] p, output logic [WL-1:0] ins);
    int tr;
    bus1.br_taken = br; bus1.br_offset = off; bus1.out_ready = 1'b1;
    wait_req1(tr, a);
    bus1.br_taken = 1'b0; bus1.br_offset = 32'hFFFF_FF00; bus1.out_ready = 1'b0;
    wait_valid1(tv, p, ins);
  endtask

  task automatic test_reset();
    rst = 1'b0; start1 = 1'b0; halt1 = 1'b0; start3 = 1'b0; halt3 = 1'b0;
    bus1.out_ready = 1'b0; bus1.br_taken = 1'b0; bus1.br_offset = '0;
    bus3.out_ready = 1'b0; bus3.br_taken = 1'b0; bus3.br_offset = '0;
    repeat (3) @(negedge clk);
    checks++;
    if (bus1.mem_req !== 1'b0 || bus1.instr_valid !== 1'b0 || busy1 !== 1'b0) begin
      failures++;
      $display("FAIL reset_ctrl: req=%b valid=%b busy=%b, want 0 0 0", bus1.mem_req, bus1.instr_valid, busy1);
    end
    checks++;
    if (bus1.pc !== '0 || bus1.mem_addr !== '0 || bus1.instr !== '0) begin
      failures++;
      $display("FAIL reset_data: pc=%h addr=%h instr=%h, want 0", bus1.pc, bus1.mem_addr, bus1.instr);
    end
    rst = 1'b1;
    repeat (2) @(negedge clk);
    checks++;
    if (busy1 !== 1'b0 || busy3 !== 1'b0 || bus1.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL reset_idle: busy1=%b busy3=%b req=%b, want 0 0 0", busy1, busy3, bus1.mem_req);
    end
  endtask

  task automatic test_start();
    int t0, tv; logic [AW-1:0] p; logic [WL-1:0] ins; exp_t e;
    e.addr = 8'h00; e.data = memfn(8'h00); sb1.push_back(e);
    start1 = 1'b1; t0 = cyc;
    @(negedge clk); start1 = 1'b0;
    checks++;
    if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 8'h00 || busy1 !== 1'b1) begin
      failures++;
      $display("FAIL start_req: req=%b addr=%h busy=%b, want 1 00 1", bus1.mem_req, bus1.mem_addr, busy1);
    end
    @(negedge clk);
    checks++;
    if (bus1.mem_req !== 1'b0 || bus1.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL start_wait: req=%b valid=%b, want 0 0", bus1.mem_req, bus1.instr_valid);
    end
    wait_valid1(tv, p, ins);
    checks++;
    if (tv < 0 || tv - t0 != 3) begin
      failures++;
      $display("FAIL start_latency: valid at cycle %0d after start, want 3", (tv < 0) ? -1 : tv - t0);
    end
    e = sb1.pop_front();
    checks++;
    if (p !== e.addr || ins !== e.data) begin
      failures++;
      $display("FAIL start_instr: pc=%h instr=%h, want pc=%h instr=%h", p, ins, e.addr, e.data);
    end
  endtask

  task automatic test_stream();
    logic [AW-1:0] exp_a [3] = '{8'h04, 8'h08, 8'h0C};
    int tprev, tr, tv; logic [AW-1:0] a, p; logic [WL-1:0] ins; exp_t e;
    tprev = cyc;
    bus1.out_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      e.addr = exp_a[i]; e.data = memfn(exp_a[i]); sb1.push_back(e);
      wait_req1(tr, a);
      checks++;
      if (tr < 0 || a !== exp_a[i]) begin
        failures++;
        $display("FAIL stream_addr[%0d]: addr=%h t=%0d, want %h", i, a, tr, exp_a[i]);
      end
      wait_valid1(tv, p, ins);
      if (i == 2) bus1.out_ready = 1'b0;
      checks++;
      if (tv < 0 || tv - tprev != 3) begin
        failures++;
        $display("FAIL stream_spacing[%0d]: %0d cycles, want 3", i, (tv < 0) ? -1 : tv - tprev);
      end
      e = sb1.pop_front();
      checks++;
      if (p !== e.addr || ins !== e.data) begin
        failures++;
        $display("FAIL stream_instr[%0d]: pc=%h instr=%h, want %h %h", i, p, ins, e.addr, e.data);
      end
      tprev = tv;
    end
  endtask

  task automatic test_branch_wrap();
    logic          br_t [4] = '{1'b1, 1'b1, 1'b1, 1'b0};
    logic [WL-1:0] off_t[4] = '{32'hFFFF_FFFC, 32'hFFFF_FFF8, 32'h0000_01FC, 32'h1234_5678};
    logic [AW-1:0] nxt_t[4] = '{8'h08, 8'h00, 8'hFC, 8'h00};
    int tv; logic [AW-1:0] a, p; logic [WL-1:0] ins; exp_t e;
    for (int i = 0; i < 4; i++) begin
      e.addr = nxt_t[i]; e.data = memfn(nxt_t[i]); sb1.push_back(e);
      xfer1(br_t[i], off_t[i], a, tv, p, ins);
      checks++;
      if (a !== nxt_t[i]) begin
        failures++;
        $display("FAIL branch_addr[%0d]: addr=%h, want %h", i, a, nxt_t[i]);
      end
      e = sb1.pop_front();
      checks++;
      if (tv < 0 || p !== e.addr || ins !== e.data) begin
        failures++;
        $display("FAIL branch_instr[%0d]: pc=%h instr=%h, want %h %h", i, p, ins, e.addr, e.data);
      end
    end
  endtask

  task automatic test_backpressure();
    int reqs, moved, tv; logic [AW-1:0] p0, a, p; logic [WL-1:0] i0, ins; exp_t e;
`ifdef FETCH_PERF_CNT_EN
    logic [15:0] s0;
    s0 = scnt1;
`endif
    p0 = bus1.pc; i0 = bus1.instr; reqs = 0; moved = 0;
    bus1.br_taken = 1'b1; bus1.br_offset = 32'h0000_0040;
    repeat (5) begin
      @(negedge clk);
      if (bus1.mem_req) reqs++;
      if (bus1.pc !== p0 || bus1.instr !== i0 || bus1.instr_valid !== 1'b1) moved++;
    end
    checks++;
    if (reqs != 0) begin
      failures++;
      $display("FAIL bp_no_req: %0d requests during stall, want 0", reqs);
    end
    checks++;
    if (moved != 0) begin
      failures++;
      $display("FAIL bp_stable: outputs changed in %0d cycles, want 0", moved);
    end
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (16'(scnt1 - s0) !== 16'd5) begin
      failures++;
      $display("FAIL bp_stall_count: delta=%0d, want 5", 16'(scnt1 - s0));
    end
`endif
    e.addr = p0 + 8'h04; e.data = memfn(p0 + 8'h04); sb1.push_back(e);
    xfer1(1'b0, 32'h0000_0040, a, tv, p, ins);
    checks++;
    if (a !== p0 + 8'h04) begin
      failures++;
      $display("FAIL bp_next_addr: addr=%h, want %h", a, p0 + 8'h04);
    end
    e = sb1.pop_front();
    checks++;
    if (tv < 0 || p !== e.addr || ins !== e.data) begin
      failures++;
      $display("FAIL bp_instr: pc=%h instr=%h, want %h %h", p, ins, e.addr, e.data);
    end
  endtask

  task automatic test_halt_hold();
    int tr, tv; logic [AW-1:0] a, p; logic [WL-1:0] ins; exp_t e;
    halt1 = 1'b1; bus1.out_ready = 1'b1;
    @(negedge clk); halt1 = 1'b0; bus1.out_ready = 1'b0;
    checks++;
    if (busy1 !== 1'b0 || bus1.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_hold: busy=%b valid=%b, want 0 0", busy1, bus1.instr_valid);
    end
    // halt alongside start in IDLE must not leave a pending stop behind
    halt1 = 1'b1; start1 = 1'b1;
    @(negedge clk); halt1 = 1'b0; start1 = 1'b0;
    checks++;
    if (bus1.mem_req !== 1'b1 || bus1.mem_addr !== 8'h00) begin
      failures++;
      $display("FAIL restart_req: req=%b addr=%h, want 1 00", bus1.mem_req, bus1.mem_addr);
    end
    e.addr = 8'h00; e.data = memfn(8'h00); sb1.push_back(e);
    wait_valid1(tv, p, ins);
    e = sb1.pop_front();
    checks++;
    if (tv < 0 || p !== e.addr || ins !== e.data) begin
      failures++;
      $display("FAIL restart_instr: pc=%h instr=%h, want %h %h", p, ins, e.addr, e.data);
    end
    bus1.out_ready = 1'b1;
    wait_req1(tr, a);
    bus1.out_ready = 1'b0;
    checks++;
    if (tr < 0 || a !== 8'h04) begin
      failures++;
      $display("FAIL restart_continue: addr=%h t=%0d, want 04", a, tr);
    end
    wait_valid1(tv, p, ins);
`ifdef FETCH_PERF_CNT_EN
    checks++;
    if (fcnt1 !== 16'(hs1)) begin
      failures++;
      $display("FAIL fetch_count: got %0d, want %0d", fcnt1, hs1);
    end
`endif
  endtask

  task automatic test_halt_pending();
    int t0, tv, reqs; exp_t e;
    e.addr = 8'h00; e.data = memfn(8'h00); sb3.push_back(e);
    bus3.out_ready = 1'b0;
    start3 = 1'b1; t0 = cyc;
    @(negedge clk); start3 = 1'b0;
    @(negedge clk); halt3 = 1'b1;
    @(negedge clk); halt3 = 1'b0;
    tv = -1;
    for (int i = 0; i < 20; i++) begin
      if (bus3.instr_valid) begin tv = cyc; break; end
      @(negedge clk);
    end
    checks++;
    if (tv < 0 || tv - t0 != 5) begin
      failures++;
      $display("FAIL halt_latency: valid at %0d cycles after start, want 5", (tv < 0) ? -1 : tv - t0);
    end
    e = sb3.pop_front();
    checks++;
    if (bus3.pc !== e.addr || bus3.instr !== e.data) begin
      failures++;
      $display("FAIL halt_instr: pc=%h instr=%h, want %h %h", bus3.pc, bus3.instr, e.addr, e.data);
    end
    bus3.out_ready = 1'b1;
    @(negedge clk); bus3.out_ready = 1'b0;
    checks++;
    if (busy3 !== 1'b0 || bus3.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL halt_idle: busy=%b valid=%b, want 0 0", busy3, bus3.instr_valid);
    end
    reqs = 0;
    repeat (6) begin @(negedge clk); if (bus3.mem_req || busy3) reqs++; end
    checks++;
    if (reqs != 0) begin
      failures++;
      $display("FAIL halt_quiet: %0d active cycles after halt, want 0", reqs);
    end
  endtask

  task automatic test_async_reset();
    int act;
    start3 = 1'b1;
    @(negedge clk); start3 = 1'b0;
    @(negedge clk);
    checks++;
    if (busy3 !== 1'b1 || bus3.mem_req !== 1'b0) begin
      failures++;
      $display("FAIL ar_in_wait: busy=%b req=%b, want 1 0", busy3, bus3.mem_req);
    end
    #2 rst = 1'b0;
    #1;
    checks++;
    if (busy3 !== 1'b0 || bus3.mem_req !== 1'b0 || bus3.instr_valid !== 1'b0 ||
        busy1 !== 1'b0 || bus1.instr_valid !== 1'b0) begin
      failures++;
      $display("FAIL ar_immediate: busy3=%b req3=%b valid3=%b busy1=%b valid1=%b, want all 0",
               busy3, bus3.mem_req, bus3.instr_valid, busy1, bus1.instr_valid);
    end
    @(negedge clk); rst = 1'b1;
    act = 0;
    repeat (6) begin
      @(negedge clk);
      if (busy3 || bus3.mem_req || bus3.instr_valid) act++;
    end
    checks++;
    if (act != 0) begin
      failures++;
      $display("FAIL ar_stay_idle: %0d active cycles after release, want 0", act);
    end
  endtask

  initial begin
    test_reset();
    test_start();
    test_stream();
    test_branch_wrap();
    test_backpressure();
    test_halt_hold();
    test_halt_pending();
    test_async_reset();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_controller.md
Name: fetch_controller

Overview:
Sequencer for the fetch datapath. It owns the program counter and drives the instruction-memory request (getInstruction) and address. It waits the fixed memory latency, captures the instruction word and presents it to decode through a valid/ready handshake. Branch redirects and halt requests from downstream are applied at the handshake boundary, so fetch is strictly one instruction in flight.

Parameters:
WORD_LEN, 32, instruction word and branch offset width
MEM_CELL_SIZE, 8, PC / instruction-memory address width
MEM_LATENCY, 1, cycles from mem_req to mem_data valid (legal range 1..15)
RESET_PC, 0, first fetch address after start

Ports:
clk  in  1  system clock, rising edge
rst  in  1  reset, asynchronous, active-low
start  in  1  begin fetching from RESET_PC (honoured only in IDLE)
halt  in  1  stop after the current instruction is handed off
out_ready  in  1  decode accepts instr this cycle
br_taken  in  1  redirect; sampled only on a handshake
br_offset  in  WORD_LEN  signed byte offset relative to pc
mem_data  in  WORD_LEN  instruction word from instruction memory
mem_req  out  1  getInstruction strobe, one cycle per fetch
mem_addr  out  MEM_CELL_SIZE  fetch address
pc  out  MEM_CELL_SIZE  address of instr currently held
instr  out  WORD_LEN  captured instruction
instr_valid  out  1  instr/pc valid for decode
busy  out  1  high in every state except IDLE

Behaviour:
- Reset (rst=0, asynchronous): state=IDLE. mem_req, instr_valid and busy are 0. pc, mem_addr, instr and the internal fetch_addr are 0. The latency counter and halt_pending are cleared. Assertion mid-fetch aborts the fetch immediately; no instruction is presented.
- FSM states: IDLE, REQ, WAIT, HOLD.
- IDLE:
  - start=1: fetch_addr<=RESET_PC, next state REQ.
  - Otherwise stay in IDLE. halt is ignored in IDLE.
- REQ (exactly 1 cycle):
  - mem_req=1, mem_addr=fetch_addr.
  - Load the latency counter with MEM_LATENCY-1, then go to WAIT.
- WAIT:
  - mem_req=0. mem_addr holds its value.
  - Decrement the counter each cycle.
  - On the cycle the counter reads 0: instr<=mem_data, pc<=fetch_addr, then go to HOLD.
  - The WAIT stay is exactly MEM_LATENCY cycles.
- HOLD:
  - instr_valid=1. instr and pc are stable until the handshake.
  - Handshake = instr_valid & out_ready. On the handshake:
    - Next address: fetch_addr <= br_taken ? pc + br_offset[MEM_CELL_SIZE-1:0] : pc + 4. Both sums are modulo 2^MEM_CELL_SIZE, so they wrap (e.g. 0xFC+4=0x00, 0x04+0xF8=0xFC).
    - If halt or halt_pending: go to IDLE, clear halt_pending, instr_valid=0 the next cycle.
    - Otherwise go to REQ.
  - br_taken and br_offset are ignored on any cycle without a handshake.
- Halt while busy:
  - halt=1 in REQ or WAIT sets sticky halt_pending.
  - The in-flight fetch completes and is presented. After its handshake the FSM goes to IDLE.
- start outside IDLE is ignored.
- Timing (MEM_LATENCY=L): start sampled at edge 0 → REQ in cycle 1 → WAIT in cycles 2..L+1 → instr_valid in cycle L+2. Back-to-back throughput is one instruction per L+2 cycles with out_ready held high.
- Backpressure: out_ready=0 holds HOLD indefinitely. There is no new mem_req and outputs do not change.

Optional Feature:
Macro FETCH_PERF_CNT_EN.
- Defined: adds outputs fetch_count[15:0] and stall_count[15:0], both reset to 0 by rst.
  - fetch_count increments on each handshake.
  - stall_count increments on each HOLD cycle with out_ready=0.
  - Both saturate at 0xFFFF. Neither is cleared by start.
- Undefined: the ports and counters do not exist. All other behaviour is identical.

Test Plan:
- Reset/start: rst low then released, start pulse, L=1, mem returns 0xDEADBEEF for addr 0x00 → mem_req=1 one cycle with mem_addr=0x00; instr_valid in cycle 3 with instr=0xDEADBEEF, pc=0x00.
- Sequential stream: out_ready=1 constant, 4 fetches → mem_addr sequence 0x00, 0x04, 0x08, 0x0C; handshakes spaced exactly 3 cycles apart.
- Branch and wrap: handshake at pc=0x08 with br_taken=1, br_offset=0xFFFFFFF8 → next mem_addr=0x00. Handshake at pc=0xFC with br_taken=0 → next mem_addr=0x00.
- Backpressure and ignored branch: out_ready=0 for 5 cycles with br_taken=1 → no mem_req, instr/pc stable; then out_ready=1, br_taken=0 → next mem_addr=pc+4. With FETCH_PERF_CNT_EN defined, stall_count=5.
- Halt pending and MEM_LATENCY=3: halt pulsed during WAIT → instruction still presented 5 cycles after start; after its handshake, busy=0 and no further mem_req.
- Async reset mid-WAIT: rst low asynchronously between edges → mem_req, instr_valid, busy=0 immediately; after release with no start, stays IDLE.
